// File: rtl/sigma_delta_mod_mc_if.sv
// Sample/result bundle for the multi-channel sigma-delta modulator.
// The datapath side (master) drives samples and strobes; the modulator
// (slave) returns quantiser codes and overload status.
interface sigma_delta_mod_mc_if #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 1,
  parameter int CHANNELS  = 2,
  parameter int OVL_CNT_W = 16
);
  logic                          en;
  logic                          order_sel;
  logic [CHANNELS*WIDTH-1:0]     in;
  logic                          ovl_clr;
  logic [CHANNELS*OUT_WIDTH-1:0] sd_out;
  logic [CHANNELS-1:0]           ovl;
  logic                          ovl_sticky;
  logic [OVL_CNT_W-1:0]          ovl_cnt;

  modport master (
    output en, order_sel, in, ovl_clr,
    input  sd_out, ovl, ovl_sticky, ovl_cnt
  );

  modport slave (
    input  en, order_sel, in, ovl_clr,
    output sd_out, ovl, ovl_sticky, ovl_cnt
  );
endinterface

// File: rtl/sigma_delta_mod_mc.sv
// Multi-channel, multi-bit error-feedback sigma-delta modulator with
// run-time 1st/2nd order selection, saturating quantiser, per-channel
// overload flags and a shared saturating overload event counter.
module sigma_delta_mod_mc #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 1,
  parameter int CHANNELS  = 2,
  parameter int OVL_CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  sigma_delta_mod_mc_if.slave bus
);

  // Error word width; v needs WIDTH+3 bits so u + 2*e1 - e2 never wraps.
  localparam int L  = WIDTH - OUT_WIDTH + 1;
  localparam int VW = WIDTH + 3;

  localparam logic [L-1:0]          E_MID   = {1'b1, {(L-1){1'b0}}};
  localparam logic signed [VW-1:0]  Y_MAX   = $signed({{(VW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}});
  localparam logic signed [VW-1:0]  E_MAX   = $signed({{(VW-L){1'b0}}, {L{1'b1}}});
  localparam logic [OVL_CNT_W-1:0]  CNT_ONE = {{(OVL_CNT_W-1){1'b0}}, 1'b1};

  // Quantiser output saturation to the unsigned code range.
  function automatic logic [OUT_WIDTH-1:0] sat_code(input logic signed [VW-1:0] q);
    if (q[VW-1])    return '0;
    if (q > Y_MAX)  return '1;
    return q[OUT_WIDTH-1:0];
  endfunction

  // Residual error clamp to the unsigned L-bit error word.
  function automatic logic [L-1:0] sat_err(input logic signed [VW-1:0] r);
    if (r[VW-1])    return '0;
    if (r > E_MAX)  return '1;
    return r[L-1:0];
  endfunction

  // Event counter increment that parks at all-ones.
  function automatic logic [OVL_CNT_W-1:0] sat_inc(input logic [OVL_CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_ONE;
  endfunction

  logic                          r_order;
  logic [L-1:0]                  r_e1_p1 [CHANNELS];
  logic [L-1:0]                  r_e2_p1 [CHANNELS];
  logic [CHANNELS*OUT_WIDTH-1:0] r_sd_out_p1;
  logic [CHANNELS-1:0]           r_ovl_p1;
  logic                          r_ovl_sticky;
  logic [OVL_CNT_W-1:0]          r_ovl_cnt;

  logic signed [VW-1:0]          w_u_p0  [CHANNELS];
  logic signed [VW-1:0]          w_e1_p0 [CHANNELS];
  logic signed [VW-1:0]          w_e2_p0 [CHANNELS];
  logic signed [VW-1:0]          w_v_p0  [CHANNELS];
  logic signed [VW-1:0]          w_q_p0  [CHANNELS];
  logic signed [VW-1:0]          w_yx_p0 [CHANNELS];
  logic [OUT_WIDTH-1:0]          w_y_p0  [CHANNELS];
  logic [L-1:0]                  w_e_p0  [CHANNELS];
  logic [CHANNELS-1:0]           w_ovl_p0;
  logic [CHANNELS*OUT_WIDTH-1:0] w_y_flat_p0;
  logic                          w_flush;
  logic                          w_step;
  logic                          w_ovl_evt;

  // An order change consumes the strobe as a flush; otherwise the strobe advances the loop.
  assign w_flush   = bus.en && (bus.order_sel != r_order);
  assign w_step    = bus.en && !w_flush;
  assign w_ovl_evt = w_step && (|w_ovl_p0);

  // Stage p0: offset-binary conversion, error feedback, quantise and residual per channel.
  always_comb begin
    w_ovl_p0    = '0;
    w_y_flat_p0 = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_u_p0[k]  = $signed({3'b000, ~bus.in[k*WIDTH+WIDTH-1], bus.in[k*WIDTH +: WIDTH-1]});
      w_e1_p0[k] = $signed({{(VW-L){1'b0}}, r_e1_p1[k]});
      w_e2_p0[k] = $signed({{(VW-L){1'b0}}, r_e2_p1[k]});
      w_v_p0[k]  = r_order ? (w_u_p0[k] + (w_e1_p0[k] <<< 1) - w_e2_p0[k])
                           : (w_u_p0[k] + w_e1_p0[k]);
      w_q_p0[k]  = w_v_p0[k] >>> L;
      w_y_p0[k]  = sat_code(w_q_p0[k]);
      w_yx_p0[k] = $signed({{(VW-OUT_WIDTH){1'b0}}, w_y_p0[k]});
      w_e_p0[k]  = sat_err(w_v_p0[k] - (w_yx_p0[k] <<< L));
      w_ovl_p0[k] = (w_q_p0[k] != w_yx_p0[k]);
      w_y_flat_p0[k*OUT_WIDTH +: OUT_WIDTH] = w_y_p0[k];
    end
  end

  // Stage p1: loop state (stored order and error history), reloaded on reset or order change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_order <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_e1_p1[k] <= E_MID;
        r_e2_p1[k] <= E_MID;
      end
    end else if (w_flush) begin
      r_order <= bus.order_sel;
      for (int k = 0; k < CHANNELS; k++) begin
        r_e1_p1[k] <= E_MID;
        r_e2_p1[k] <= E_MID;
      end
    end else if (w_step) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_e2_p1[k] <= r_e1_p1[k];
        r_e1_p1[k] <= w_e_p0[k];
      end
    end
  end

  // Stage p1: registered codes and per-channel overload flags, held between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sd_out_p1 <= '0;
      r_ovl_p1    <= '0;
    end else if (w_step) begin
      r_sd_out_p1 <= w_y_flat_p0;
      r_ovl_p1    <= w_ovl_p0;
    end
  end

  // Shared overload accounting; a new event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovl_sticky <= 1'b0;
      r_ovl_cnt    <= '0;
    end else if (w_ovl_evt) begin
      r_ovl_sticky <= 1'b1;
      r_ovl_cnt    <= bus.ovl_clr ? CNT_ONE : sat_inc(r_ovl_cnt);
    end else if (bus.ovl_clr) begin
      r_ovl_sticky <= 1'b0;
      r_ovl_cnt    <= '0;
    end
  end

  assign bus.sd_out     = r_sd_out_p1;
  assign bus.ovl        = r_ovl_p1;
  assign bus.ovl_sticky = r_ovl_sticky;
  assign bus.ovl_cnt    = r_ovl_cnt;

endmodule

// File: tb/tb_sigma_delta_mod_mc.sv
// Bench for sigma_delta_mod_mc: directed scenarios plus randomized traffic,
// every cycle compared against an arithmetic reference model.
module tb_sigma_delta_mod_mc;
  localparam int W  = 16;
  localparam int OW = 1;
  localparam int CH = 2;
  localparam int CW = 2;
  localparam longint TWO_L = 64'sd1 << (W - OW + 1);
  localparam longint YMAX  = (64'sd1 << OW) - 1;
  localparam longint CMAX  = (64'sd1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sigma_delta_mod_mc_if #(.WIDTH(W), .OUT_WIDTH(OW), .CHANNELS(CH), .OVL_CNT_W(CW)) bus ();

  sigma_delta_mod_mc #(.WIDTH(W), .OUT_WIDTH(OW), .CHANNELS(CH), .OVL_CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     errors = 0;
  int     checks = 0;
  string  phase  = "init";
  longint s [CH];
  longint m_e1 [CH];
  longint m_e2 [CH];
  longint m_sd [CH];
  bit     m_ovl [CH];
  bit     m_order;
  bit     m_sticky;
  longint m_cnt;
  logic signed [W-1:0] rs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Reference behaviour of one clock edge, straight from the arithmetic rules.
  task automatic model_step(input bit r, input bit e, input bit os, input bit clr);
    bit any;
    longint u, v, q, y, er;
    any = 1'b0;
    if (r) begin
      m_order = 1'b0;
      for (int k = 0; k < CH; k++) begin
        m_e1[k] = TWO_L / 2; m_e2[k] = TWO_L / 2; m_sd[k] = 0; m_ovl[k] = 1'b0;
      end
      m_sticky = 1'b0;
      m_cnt = 0;
      return;
    end
    if (e) begin
      if (os != m_order) begin
        m_order = os;
        for (int k = 0; k < CH; k++) begin
          m_e1[k] = TWO_L / 2; m_e2[k] = TWO_L / 2;
        end
      end else begin
        for (int k = 0; k < CH; k++) begin
          u = s[k] + (64'sd1 << (W - 1));
          v = m_order ? (u + 2 * m_e1[k] - m_e2[k]) : (u + m_e1[k]);
          q = floor_div(v, TWO_L);
          y = (q < 0) ? 0 : ((q > YMAX) ? YMAX : q);
          er = v - y * TWO_L;
          if (er < 0) er = 0;
          if (er > TWO_L - 1) er = TWO_L - 1;
          m_e2[k] = m_e1[k];
          m_e1[k] = er;
          m_sd[k] = y;
          m_ovl[k] = (q != y);
          if (q != y) any = 1'b1;
        end
      end
    end
    if (any) begin
      m_sticky = 1'b1;
      m_cnt = clr ? 1 : ((m_cnt == CMAX) ? CMAX : m_cnt + 1);
    end else if (clr) begin
      m_sticky = 1'b0;
      m_cnt = 0;
    end
  endtask

  // Apply one clock of stimulus, advance the model, then compare all outputs.
  task automatic step(input bit r, input bit e, input bit os, input bit clr);
    logic [CH*OW-1:0] ev;
    logic [CH-1:0]    eo;
    rst = r;
    bus.en = e;
    bus.order_sel = os;
    bus.ovl_clr = clr;
    for (int k = 0; k < CH; k++) bus.in[k*W +: W] = s[k][W-1:0];
    @(posedge clk);
    model_step(r, e, os, clr);
    #1;
    for (int k = 0; k < CH; k++) begin
      ev[k*OW +: OW] = m_sd[k][OW-1:0];
      eo[k] = m_ovl[k];
    end
    chk("sd_out", 64'(bus.sd_out), 64'(ev));
    chk("ovl", 64'(bus.ovl), 64'(eo));
    chk("ovl_sticky", 64'(bus.ovl_sticky), 64'(m_sticky));
    chk("ovl_cnt", 64'(bus.ovl_cnt), 64'(m_cnt));
  endtask

  // Flush to order 1, flush to order 2, one sample with y=1/e=0, then an underflow sample.
  task automatic ovl_burst(input bit clr_last);
    s[0] = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("burst_pre_y", 64'(bus.sd_out[0]), 64'(1));
    s[0] = -32768;
    step(1'b0, 1'b1, 1'b1, clr_last);
  endtask

  int seq2 [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
  int cexp [4] = '{1, 2, 3, 3};
  int ones;
  bit ro;

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.order_sel = 1'b0; bus.ovl_clr = 1'b0; bus.in = '0;
    s[0] = 0; s[1] = 0;

    phase = "reset";
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_sd", 64'(bus.sd_out), 64'(0));
    chk("rst_ovl", 64'(bus.ovl), 64'(0));
    chk("rst_sticky", 64'(bus.ovl_sticky), 64'(0));
    chk("rst_cnt", 64'(bus.ovl_cnt), 64'(0));

    phase = "order1_mid";
    s[0] = 0; s[1] = -32768;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("ch0_alt", 64'(bus.sd_out[0]), 64'((i % 2 == 0) ? 1 : 0));
      chk("ch1_zero", 64'(bus.sd_out[1]), 64'(0));
      chk("no_ovl", 64'(bus.ovl), 64'(0));
    end

    phase = "order1_density";
    s[0] = 16384;
    ones = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ones += int'(bus.sd_out[0]);
    end
    chk("ones_300pm1", 64'((ones >= 299 && ones <= 301) ? 1 : 0), 64'(1));
    chk("no_sticky", 64'(bus.ovl_sticky), 64'(0));

    phase = "order2_seq";
    s[0] = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("ch0_seq", 64'(bus.sd_out[0]), 64'(seq2[i]));
    end

    phase = "overload";
    for (int b = 0; b < 4; b++) begin
      ovl_burst(1'b0);
      chk("ovl_sd0", 64'(bus.sd_out[0]), 64'(0));
      chk("ovl_flags", 64'(bus.ovl), 64'(1));
      chk("ovl_sticky", 64'(bus.ovl_sticky), 64'(1));
      chk("ovl_cnt_sat", 64'(bus.ovl_cnt), 64'(cexp[b]));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_cnt", 64'(bus.ovl_cnt), 64'(0));
    chk("clr_sticky", 64'(bus.ovl_sticky), 64'(0));
    ovl_burst(1'b1);
    chk("clr_evt_cnt", 64'(bus.ovl_cnt), 64'(1));
    chk("clr_evt_sticky", 64'(bus.ovl_sticky), 64'(1));

    phase = "en_gap";
    for (int i = 0; i < 5; i++) begin
      rs = W'($urandom); s[0] = rs;
      rs = W'($urandom); s[1] = rs;
      step(1'b0, 1'b0, (i % 2 == 0), 1'b0);
      chk("hold_sd", 64'(bus.sd_out), 64'(0));
      chk("hold_ovl", 64'(bus.ovl), 64'(1));
      chk("hold_cnt", 64'(bus.ovl_cnt), 64'(1));
    end

    phase = "mid_reset";
    s[0] = 12345; s[1] = -20000;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mr_sd", 64'(bus.sd_out), 64'(0));
    chk("mr_ovl", 64'(bus.ovl), 64'(0));
    chk("mr_sticky", 64'(bus.ovl_sticky), 64'(0));
    chk("mr_cnt", 64'(bus.ovl_cnt), 64'(0));
    s[0] = 0; s[1] = -32768;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("resume_alt", 64'(bus.sd_out[0]), 64'((i % 2 == 0) ? 1 : 0));
      chk("resume_ch1", 64'(bus.sd_out[1]), 64'(0));
    end

    phase = "random";
    ro = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < CH; k++) begin
        case ($urandom_range(0, 3))
          0: s[k] = 32767;
          1: s[k] = -32768;
          default: begin rs = W'($urandom); s[k] = rs; end
        endcase
      end
      if ($urandom_range(0, 29) == 0) ro = ~ro;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ro,
           ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sigma_delta_mod_mc.md
Name: sigma_delta_mod_mc

Overview:
- Multi-channel, multi-bit sigma-delta modulator using an error-feedback loop.
- Order (1st or 2nd) is selectable at run time. Output quantiser saturates, with per-channel overload reporting and a shared overload event counter.
- Sits between the DSP datapath (signed samples) and DAC/PWM output stages. Successor to the single-channel 1st-order modulator.

Parameters:
- WIDTH, 16, input sample width per channel (signed two's complement), >= OUT_WIDTH+2.
- OUT_WIDTH, 1, quantiser output width per channel (unsigned code).
- CHANNELS, 2, number of independent parallel channels.
- OVL_CNT_W, 16, width of the saturating overload event counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  sample strobe; all channels advance one step when high.
- order_sel  input  1  0 = 1st order, 1 = 2nd order; sampled only when en=1.
- in  input  CHANNELS*WIDTH  signed samples; channel k occupies bits [k*WIDTH +: WIDTH].
- ovl_clr  input  1  synchronous clear of ovl_sticky and ovl_cnt.
- sd_out  output  CHANNELS*OUT_WIDTH  registered quantiser codes, same packing as in.
- ovl  output  CHANNELS  registered per-channel saturation flag for the last processed sample.
- ovl_sticky  output  1  set by any channel overload, held until ovl_clr.
- ovl_cnt  output  OVL_CNT_W  count of en-samples where any channel overloaded; saturates at all-ones.

Behaviour:
- Definitions:
  - L = WIDTH-OUT_WIDTH+1.
  - u = in with MSB inverted (offset binary, 0..2^WIDTH-1).
  - Per channel, e1 is the previous quantisation error and e2 is the error before that (unsigned, L bits each).
  - Internal v is signed, at least WIDTH+3 bits; no wrap permitted.
- Loop, on en=1 with order unchanged:
  - v = u + e1 (order 1), or v = u + 2*e1 - e2 (order 2).
  - q = floor(v / 2^L), arithmetic.
  - y = clamp(q, 0, 2^OUT_WIDTH-1).
  - e = clamp(v - y*2^L, 0, 2^L-1).
  - Update: e2 <= e1, e1 <= e, sd_out <= y.
  - ovl[k] <= (q != y) for each channel.
- Latency: sd_out/ovl reflect the sample presented on the en cycle, valid from the next clock edge. Outputs hold when en=0.
- Mean output ≈ u/2^L. Codes above 2^(OUT_WIDTH-1) are headroom for 2nd-order noise; for OUT_WIDTH=1 the full input range maps to density 0..1.
- Order change:
  - If en=1 and order_sel differs from the stored order, update the stored order and reload e1=e2=2^(L-1) in all channels.
  - sd_out and ovl are unchanged that cycle; that sample is discarded (one-sample flush).
  - order_sel is ignored when en=0.
- Overload accounting, per en-cycle in which any ovl bit is set:
  - ovl_sticky <= 1.
  - ovl_cnt increments, holding at 2^OVL_CNT_W-1.
  - With ovl_clr alone: ovl_sticky <= 0 and ovl_cnt <= 0.
  - ovl_clr and an overload in the same cycle: ovl_sticky=1, ovl_cnt=1. The new event is kept.
  - ovl_clr is effective regardless of en.
- Reset (rst=1, priority over en/ovl_clr):
  - e1 = e2 = 2^(L-1) for all channels; stored order = 0.
  - sd_out = 0, ovl = 0, ovl_sticky = 0, ovl_cnt = 0.
  - Reset mid-stream discards all loop state; the first en after reset uses the reset errors.
  - If order_sel=1 on the first en after reset, the order-change flush applies.
- Channels are fully independent except for the shared ovl_sticky/ovl_cnt and the order/flush.

Test Plan:
- Defaults, order 1, ch0 in=0 (u=32768), ch1 in=-32768, en every cycle:
  - ch0 sd_out = 1,0,1,0,…
  - ch1 stays 0.
  - ovl=0 throughout.
- Order 1, ch0 in=16384 (u=49152) for 400 samples: count of ones = 300 ±1, no ovl.
- Order 2 after flush, ch0 in=0:
  - sd_out sequence 1,0,0,1,1,0,0,1…
  - Internal e sequence 0,0,32768,32768,0,…
- Overload, order 2, after flush:
  - ch0 in=0 for one sample (y=1, e=0), then in=-32768: v=-32768, q=-1.
  - Required: sd_out=0, ovl[0]=1, ovl_sticky=1, ovl_cnt=1, e clamped to 0.
- Counter saturation and clear, OVL_CNT_W=2, with repeated overload stimulus:
  - ovl_cnt 1,2,3,3.
  - ovl_clr alone gives 0.
  - ovl_clr coincident with overload gives ovl_cnt=1, ovl_sticky=1.
- en gaps and reset mid-stream:
  - en low for 5 cycles: outputs hold.
  - rst pulse during order-2 run: all outputs 0 next cycle.
  - Order-1 resumption reproduces the first scenario from its start.
